fu_div_iter: RTL and testbench

//   Parametrised iterative divide functional unit for the Tomasulo core.

---
 rtl/fu_div_iter.sv | 136 +++++++++++++
 tb/tb_fu_div_iter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_div_iter.sv
// Iterative restoring divider FU: signed/unsigned quotient or remainder, one bit per cycle.
// Optional FU_DIV_EARLY_OUT_EN resolves divide-by-zero and signed MIN/-1 without iterating.
module fu_div_iter #(
  parameter int WIDTH = 32,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [ID_W-1:0]  FU_ID,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic [ID_W-1:0]  finish,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  r_q, q_q, b_q, res_q;
  logic [ID_W-1:0]   tag_q, finish_q;
  logic              rem_sel_q, qneg_q, rneg_q, div0_q, busy_q;

  logic              a_neg, b_neg, is_div0;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [WIDTH:0]    shifted, diff;
  logic [WIDTH-1:0]  r_d, q_d, quot_fix, rem_fix;

  assign a_neg   = op[0] & A[WIDTH-1];
  assign b_neg   = op[0] & B[WIDTH-1];
  assign a_abs   = a_neg ? -A : A;
  assign b_abs   = b_neg ? -B : B;
  assign is_div0 = (B == '0);

  // One restoring step: bring in the next dividend bit, keep the trial difference if non-negative.
  assign shifted  = {r_q, q_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, b_q};
  assign r_d      = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_d      = {q_q[WIDTH-2:0], ~diff[WIDTH]};
  assign quot_fix = div0_q ? '1 : (qneg_q ? -q_d : q_d);
  assign rem_fix  = rneg_q ? -r_d : r_d;

`ifdef FU_DIV_EARLY_OUT_EN
  logic             is_ovf, is_special, eo_pend_q;
  logic [WIDTH-1:0] eo_res;

  assign is_ovf     = op[0] & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);
  assign is_special = is_div0 | is_ovf;
  // div0 gives all-ones / A; MIN/-1 gives MIN (== A) / 0
  assign eo_res     = is_div0 ? (op[1] ? A : '1) : (op[1] ? '0 : A);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      tag_q     <= '0;
      finish_q  <= '0;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FU_DIV_EARLY_OUT_EN
      eo_pend_q <= 1'b0;
`endif
    end else begin
      finish_q <= '0;
`ifdef FU_DIV_EARLY_OUT_EN
      eo_pend_q <= 1'b0;
      // early-out result parked in q_q is published one cycle after accept
      if (eo_pend_q) begin
        res_q    <= q_q;
        finish_q <= tag_q;
      end
`endif
      case (state_q)
        IDLE, DONE: begin
          if (EN) begin
            tag_q     <= FU_ID;
            rem_sel_q <= op[1];
            qneg_q    <= op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_q    <= a_neg;
            div0_q    <= is_div0;
            r_q       <= '0;
            q_q       <= a_abs;
            b_q       <= b_abs;
            cnt_q     <= CW'(WIDTH);
`ifdef FU_DIV_EARLY_OUT_EN
            if (is_special) begin
              q_q       <= eo_res;
              cnt_q     <= '0;
              eo_pend_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
`else
            state_q <= CALC;
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_q    <= rem_sel_q ? rem_fix : quot_fix;
            finish_q <= tag_q;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res    = res_q;
  assign finish = finish_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_fu_div_iter.sv
// Self-checking bench for fu_div_iter: arithmetic reference model with per-cycle expectations.
module tb_fu_div_iter;
  localparam int W = 32;
`ifdef FU_DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = W;
`endif
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0, rst_n = 1'b0, EN = 1'b0;
  logic [3:0]  FU_ID = '0;
  logic [1:0]  op = '0;
  logic [31:0] A = '0, B = '0;
  logic [31:0] res;
  logic [3:0]  finish;
  logic        busy;

  fu_div_iter #(.WIDTH(W), .ID_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .FU_ID(FU_ID), .op(op),
    .A(A), .B(B), .res(res), .finish(finish), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, free_at = 0, fin_pulses = 0;
  logic [3:0]  exp_fin [int];
  logic [31:0] exp_res [int];
  bit          exp_busy[int];
  logic [31:0] res_model = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] o);
    int sa, sb;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (o[0]) begin
      if (a == MIN && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : MIN;
      sa = $signed(a);
      sb = $signed(b);
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? a % b : a / b;
  endfunction

  function automatic bit special(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    return (b == 0) || (o[0] && a == MIN && b == 32'hFFFF_FFFF);
  endfunction

  // Per-cycle compare: key = number of the rising edge just passed.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        res_model = '0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_finish", 32'(finish), 32'h0);
        chk("rst_res", res, 32'h0);
      end else begin
        if (exp_fin.exists(cyc)) res_model = exp_res[cyc];
        chk("busy", 32'(busy), 32'(exp_busy.exists(cyc)));
        chk("finish", 32'(finish), exp_fin.exists(cyc) ? 32'(exp_fin[cyc]) : 32'h0);
        chk("res", res, res_model);
      end
      if (finish != 0) fin_pulses++;
    end
  end

  task automatic wait_until(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Called just after a negedge; the request is sampled at the next edge e.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       input logic [3:0] id, output int e, output bit acc);
    int lat;
    e = cyc + 1;
    A = a; B = b; op = o; FU_ID = id; EN = 1'b1;
    acc = rst_n && (e >= free_at);
    if (acc) begin
      lat = special(a, b, o) ? SPEC_LAT : W;
      exp_fin[e + lat] = id;
      exp_res[e + lat] = ref_div(a, b, o);
      if (lat == W) begin
        for (int k = 0; k < W; k++) exp_busy[e + k] = 1'b1;
        free_at = e + W + 1;
      end else begin
        free_at = e + 1;
      end
    end
    @(negedge clk);
    EN = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom); FU_ID = 4'($urandom);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                        input logic [3:0] id, input logic [31:0] want, input int wlat,
                        input string nm);
    int e;
    bit acc;
    wait_until(free_at);
    issue(a, b, o, id, e, acc);
    chk({nm, "_acc"}, 32'(acc), 32'h1);
    while (finish == 0 && cyc < e + W + 4) @(negedge clk);
    chk({nm, "_lat"}, 32'(cyc - e), 32'(wlat));
    chk({nm, "_tag"}, 32'(finish), 32'(id));
    chk({nm, "_res"}, res, want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d want completion", cyc);
    $fatal(1);
  end

  initial begin
    int e, e0, p0, nacc, guard;
    bit acc;
    int offs[3] = '{5, 10, 20};
    int ks[$];
    logic [31:0] a, b;
    logic [1:0]  o;
    logic [3:0]  id;

    chk("pin_u_q",  ref_div(32'd100, 32'd7, 2'b00), 32'd14);
    chk("pin_u_r",  ref_div(32'd100, 32'd7, 2'b10), 32'd2);
    chk("pin_s_q",  ref_div(32'hFFFF_FF9C, 32'd7, 2'b01), 32'hFFFF_FFF2);
    chk("pin_s_r",  ref_div(32'hFFFF_FF9C, 32'd7, 2'b11), 32'hFFFF_FFFE);
    chk("pin_s_r2", ref_div(32'd100, 32'hFFFF_FFF9, 2'b11), 32'd2);
    chk("pin_ovf",  ref_div(MIN, 32'hFFFF_FFFF, 2'b01), MIN);

    repeat (3) @(negedge clk);
    chk("reset_res", res, 32'h0);
    chk("reset_finish", 32'(finish), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd100, 32'd7, 2'b00, 4'd3, 32'd14, W, "t1_quot");
    run_op(32'd100, 32'd7, 2'b10, 4'd3, 32'd2, W, "t1_rem");
    run_op(32'hFFFF_FF9C, 32'd7, 2'b01, 4'd4, 32'hFFFF_FFF2, W, "t2_nq");
    run_op(32'hFFFF_FF9C, 32'd7, 2'b11, 4'd4, 32'hFFFF_FFFE, W, "t2_nr");
    run_op(32'd100, 32'hFFFF_FFF9, 2'b01, 4'd5, 32'hFFFF_FFF2, W, "t2_dq");
    run_op(32'd100, 32'hFFFF_FFF9, 2'b11, 4'd5, 32'd2, W, "t2_dr");
    run_op(32'd5, 32'd0, 2'b00, 4'd6, 32'hFFFF_FFFF, SPEC_LAT, "t3_z_q");
    run_op(32'd5, 32'd0, 2'b10, 4'd6, 32'd5, SPEC_LAT, "t3_z_r");
    run_op(MIN, 32'hFFFF_FFFF, 2'b01, 4'd7, MIN, SPEC_LAT, "t3_ovf_q");
    run_op(MIN, 32'hFFFF_FFFF, 2'b11, 4'd7, 32'd0, SPEC_LAT, "t3_ovf_r");

    // EN pulses during CALC are dropped; EN in the DONE cycle is accepted.
    wait_until(free_at);
    issue(32'd1000, 32'd3, 2'b00, 4'd5, e0, acc);
    chk("t4_acc", 32'(acc), 32'h1);
    p0 = fin_pulses;
    foreach (offs[i]) begin
      wait_until(e0 + offs[i] - 1);
      issue($urandom, $urandom, 2'($urandom), 4'd9, e, acc);
      chk("t4_drop", 32'(acc), 32'h0);
    end
    wait_until(e0 + W);
    chk("t4_tag", 32'(finish), 32'd5);
    chk("t4_res", res, 32'd333);
    issue(32'd77, 32'd7, 2'b00, 4'd6, e, acc);
    chk("t4_done_acc", 32'(acc), 32'h1);
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_one_finish", 32'(fin_pulses - p0), 32'd1);

    // Reset in the middle of an op aborts it without a finish.
    wait_until(free_at);
    issue(32'd1234567, 32'd89, 2'b00, 4'd7, e, acc);
    wait_until(e + 14);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_res", res, 32'h0);
    chk("t5_finish", 32'(finish), 32'h0);
    ks.delete();
    foreach (exp_fin[k]) if (k > cyc) ks.push_back(k);
    foreach (ks[i]) begin
      exp_fin.delete(ks[i]);
      exp_res.delete(ks[i]);
    end
    ks.delete();
    foreach (exp_busy[k]) if (k > cyc) ks.push_back(k);
    foreach (ks[i]) exp_busy.delete(ks[i]);
    free_at = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = fin_pulses;
    wait_until(cyc + W + 4);
    chk("t5_no_finish", 32'(fin_pulses - p0), 32'd0);
    run_op(32'd1234567, 32'd89, 2'b00, 4'd8, 32'd13871, W, "t5_after");

    // Random operations; some requests land while busy and must be dropped.
    nacc = 0;
    guard = 0;
    while (nacc < 1000 && guard < 5000) begin
      guard++;
      a = $urandom;
      b = $urandom;
      o = 2'($urandom);
      id = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = MIN; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        4: a = $urandom_range(0, 255);
        default: ;
      endcase
      if ($urandom_range(0, 7) != 0) wait_until(free_at - 1 + $urandom_range(0, 2));
      issue(a, b, o, id, e, acc);
      if (acc) nacc++;
    end
    chk("rand_count", 32'(nacc), 32'd1000);
    wait_until(free_at + W + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
